// File: rtl/rvga_membus_arbiter.sv
// Arbitrates the instruction and data membus masters onto one shared memory port.
// Define RVGA_ARB_ROUND_ROBIN_EN for round-robin conflicts; otherwise D has priority with an I starvation guard.
module rvga_membus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic              i_read_i,
    input  logic              i_write_i,
    input  logic [DATA_W-1:0] i_wdata_i,
    output logic [DATA_W-1:0] i_rdata_o,
    output logic              i_resp_o,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_resp_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_resp_i
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_i_resp;
    logic              w_d_resp;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_i_wins_conflict;

    assign w_i_req = i_read_i | i_write_i;
    assign w_d_req = d_read_i | d_write_i;

`ifdef RVGA_ARB_ROUND_ROBIN_EN
    // Set when the most recent grant went to D; reset points at I so D wins the first conflict.
    logic r_last_d;

    assign w_i_wins_conflict = r_last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (w_grant_d) begin
            r_last_d <= 1'b1;
        end else if (w_grant_i) begin
            r_last_d <= 1'b0;
        end
    end
`else
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [CNT_W-1:0] r_starve;
    logic             w_starved;

    assign w_starved         = (STARVE_LIMIT != 0) && (r_starve == CNT_W'(STARVE_LIMIT));
    assign w_i_wins_conflict = w_starved;

    // Counts D grants taken while I waits; saturates so a long wait cannot wrap back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_grant_i || !w_i_req) begin
            r_starve <= '0;
        end else if (w_grant_d && !w_starved && (STARVE_LIMIT != 0)) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) begin
                    w_grant_i = w_i_wins_conflict;
                    w_grant_d = !w_i_wins_conflict;
                end else begin
                    w_grant_i = w_i_req;
                    w_grant_d = w_d_req;
                end
                if (w_grant_i) begin
                    w_state_nxt = BUSY_I;
                end else if (w_grant_d) begin
                    w_state_nxt = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_i_resp = (r_state == BUSY_I) && mem_resp_i;
    assign w_d_resp = (r_state == BUSY_D) && mem_resp_i;

    // A simultaneous read+write from one master is issued as a write only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            if (w_grant_i) begin
                r_mem_addr  <= i_addr_i;
                r_mem_wdata <= i_wdata_i;
                r_mem_read  <= i_read_i & ~i_write_i;
                r_mem_write <= i_write_i;
            end else if (w_grant_d) begin
                r_mem_addr  <= d_addr_i;
                r_mem_wdata <= d_wdata_i;
                r_mem_read  <= d_read_i & ~d_write_i;
                r_mem_write <= d_write_i;
            end else if (w_i_resp || w_d_resp) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
            end
            if (w_i_resp) begin
                r_i_rdata <= mem_rdata_i;
            end
            if (w_d_resp) begin
                r_d_rdata <= mem_rdata_i;
            end
        end
    end

    assign i_resp_o    = w_i_resp;
    assign d_resp_o    = w_d_resp;
    assign i_rdata_o   = w_i_resp ? mem_rdata_i : r_i_rdata;
    assign d_rdata_o   = w_d_resp ? mem_rdata_i : r_d_rdata;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_read_o  = r_mem_read;
    assign mem_write_o = r_mem_write;

endmodule

// File: tb/tb_rvga_membus_arbiter.sv
// Directed bench for rvga_membus_arbiter: transaction-level reference model plus per-cycle compare.
// Follows RVGA_ARB_ROUND_ROBIN_EN for the expected conflict-resolution order.
module tb_rvga_membus_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic [31:0] i_addr_i;
    logic        i_read_i;
    logic        i_write_i;
    logic [31:0] i_wdata_i;
    logic [31:0] i_rdata_o;
    logic        i_resp_o;
    logic [31:0] d_addr_i;
    logic        d_read_i;
    logic        d_write_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_resp_o;
    logic [31:0] mem_addr_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_resp_i;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    rvga_membus_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_addr_i(i_addr_i),
        .i_read_i(i_read_i),
        .i_write_i(i_write_i),
        .i_wdata_i(i_wdata_i),
        .i_rdata_o(i_rdata_o),
        .i_resp_o(i_resp_o),
        .d_addr_i(d_addr_i),
        .d_read_i(d_read_i),
        .d_write_i(d_write_i),
        .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o),
        .d_resp_o(d_resp_o),
        .mem_addr_o(mem_addr_o),
        .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_resp_i(mem_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the memory port (0 none, 1 I, 2 D) and what was issued.
    int          m_owner;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_rd;
    logic        m_wr;
    logic [31:0] m_irdata;
    logic [31:0] m_drdata;
    int          m_waits;
    bit          m_last_d;
    logic        m_win_i;
    logic        m_win_d;
    logic        m_ireq;
    logic        m_dreq;

    assign m_ireq = i_read_i | i_write_i;
    assign m_dreq = d_read_i | d_write_i;

    always_comb begin
        m_win_i = 1'b0;
        m_win_d = 1'b0;
        if (m_owner == 0) begin
            if (m_ireq && m_dreq) begin
`ifdef RVGA_ARB_ROUND_ROBIN_EN
                m_win_i = m_last_d;
`else
                m_win_i = (LIMIT != 0) && (m_waits >= LIMIT);
`endif
                m_win_d = !m_win_i;
            end else begin
                m_win_i = m_ireq;
                m_win_d = m_dreq;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner  <= 0;
            m_addr   <= 32'h0;
            m_wdata  <= 32'h0;
            m_rd     <= 1'b0;
            m_wr     <= 1'b0;
            m_irdata <= 32'h0;
            m_drdata <= 32'h0;
            m_waits  <= 0;
            m_last_d <= 1'b0;
        end else begin
            if (m_win_i) begin
                m_owner <= 1;
                m_addr  <= i_addr_i;
                m_wdata <= i_wdata_i;
                m_wr    <= i_write_i;
                m_rd    <= i_read_i && !i_write_i;
            end else if (m_win_d) begin
                m_owner <= 2;
                m_addr  <= d_addr_i;
                m_wdata <= d_wdata_i;
                m_wr    <= d_write_i;
                m_rd    <= d_read_i && !d_write_i;
            end else if (m_owner != 0 && mem_resp_i) begin
                m_owner <= 0;
                m_rd    <= 1'b0;
                m_wr    <= 1'b0;
                if (m_owner == 1) m_irdata <= mem_rdata_i;
                else              m_drdata <= mem_rdata_i;
            end
            if (m_win_i || !m_ireq) m_waits <= 0;
            else if (m_win_d)       m_waits <= (m_waits + 1 > LIMIT) ? LIMIT : m_waits + 1;
            if (m_win_d)      m_last_d <= 1'b1;
            else if (m_win_i) m_last_d <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_mem_read", {31'b0, mem_read_o}, {31'b0, m_rd});
            chk("mdl_mem_write", {31'b0, mem_write_o}, {31'b0, m_wr});
            chk("mdl_mem_addr", mem_addr_o, m_addr);
            chk("mdl_mem_wdata", mem_wdata_o, m_wdata);
            chk("mdl_i_resp", {31'b0, i_resp_o}, {31'b0, (m_owner == 1) && mem_resp_i});
            chk("mdl_d_resp", {31'b0, d_resp_o}, {31'b0, (m_owner == 2) && mem_resp_i});
            chk("mdl_i_rdata", i_rdata_o, ((m_owner == 1) && mem_resp_i) ? mem_rdata_i : m_irdata);
            chk("mdl_d_rdata", d_rdata_o, ((m_owner == 2) && mem_resp_i) ? mem_rdata_i : m_drdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        string glog;
        string gexp;
        int    ngr;

        rst = 1'b1;
        i_addr_i = 32'h0; i_read_i = 1'b0; i_write_i = 1'b0; i_wdata_i = 32'h0;
        d_addr_i = 32'h0; d_read_i = 1'b0; d_write_i = 1'b0; d_wdata_i = 32'h0;
        mem_rdata_i = 32'h0; mem_resp_i = 1'b0;

        tick;
        chk("rst_mem_read", {31'b0, mem_read_o}, 32'h0);
        chk("rst_mem_write", {31'b0, mem_write_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_i_rdata", i_rdata_o, 32'h0);
        chk("rst_d_rdata", d_rdata_o, 32'h0);
        chk_en = 1'b1;
        tick;
        #2 rst = 1'b0;
        tick;

        // Single I read
        i_addr_i = 32'h100; i_read_i = 1'b1;
        tick;
        chk("t1_mem_read", {31'b0, mem_read_o}, 32'h1);
        chk("t1_mem_addr", mem_addr_o, 32'h100);
        mem_resp_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        chk("t1_i_resp", {31'b0, i_resp_o}, 32'h1);
        chk("t1_i_rdata", i_rdata_o, 32'hDEADBEEF);
        chk("t1_d_resp", {31'b0, d_resp_o}, 32'h0);
        tick;
        i_read_i = 1'b0; mem_resp_i = 1'b0;
        chk("t1_mem_read_clr", {31'b0, mem_read_o}, 32'h0);
        chk("t1_i_rdata_hold", i_rdata_o, 32'hDEADBEEF);

        // Stray response while idle
        mem_resp_i = 1'b1; mem_rdata_i = 32'h0BAD0BAD;
        #1;
        chk("t4_i_resp", {31'b0, i_resp_o}, 32'h0);
        chk("t4_d_resp", {31'b0, d_resp_o}, 32'h0);
        chk("t4_i_rdata", i_rdata_o, 32'hDEADBEEF);
        tick;
        mem_resp_i = 1'b0;
        chk("t4_mem_read", {31'b0, mem_read_o}, 32'h0);

        // One master asserting read and write together
        d_addr_i = 32'h300; d_wdata_i = 32'h55AA55AA; d_read_i = 1'b1; d_write_i = 1'b1;
        tick;
        chk("rw_mem_write", {31'b0, mem_write_o}, 32'h1);
        chk("rw_mem_read", {31'b0, mem_read_o}, 32'h0);
        chk("rw_mem_addr", mem_addr_o, 32'h300);
        mem_resp_i = 1'b1; mem_rdata_i = 32'h11112222;
        #1;
        chk("rw_d_resp", {31'b0, d_resp_o}, 32'h1);
        chk("rw_i_resp", {31'b0, i_resp_o}, 32'h0);
        tick;
        d_read_i = 1'b0; d_write_i = 1'b0; mem_resp_i = 1'b0;
        i_addr_i = 32'h104; i_read_i = 1'b1;
        tick;
        chk("i104_mem_addr", mem_addr_o, 32'h104);
        mem_resp_i = 1'b1; mem_rdata_i = 32'h01040104;
        tick;
        i_read_i = 1'b0; mem_resp_i = 1'b0;

        // Simultaneous I read and D write
        i_addr_i = 32'h200; i_read_i = 1'b1;
        d_addr_i = 32'h400; d_wdata_i = 32'h12345678; d_write_i = 1'b1;
        tick;
        chk("t2_mem_write", {31'b0, mem_write_o}, 32'h1);
        chk("t2_mem_wdata", mem_wdata_o, 32'h12345678);
        chk("t2_mem_addr", mem_addr_o, 32'h400);
        i_addr_i = 32'h999;
        tick;
        chk("t2_hold_addr", mem_addr_o, 32'h400);
        i_addr_i = 32'h200;
        mem_resp_i = 1'b1; mem_rdata_i = 32'h0;
        #1;
        chk("t2_d_resp", {31'b0, d_resp_o}, 32'h1);
        tick;
        d_write_i = 1'b0; mem_resp_i = 1'b0;
        chk("t2_idle_read", {31'b0, mem_read_o}, 32'h0);
        tick;
        chk("t2_i_read", {31'b0, mem_read_o}, 32'h1);
        chk("t2_i_addr", mem_addr_o, 32'h200);
        mem_resp_i = 1'b1; mem_rdata_i = 32'hA0A0A0A0;
        #1;
        chk("t2_i_rdata", i_rdata_o, 32'hA0A0A0A0);
        tick;
        i_read_i = 1'b0; mem_resp_i = 1'b0;

        // Both masters requesting continuously; memory answers on the first busy cycle
        i_addr_i = 32'h500; i_read_i = 1'b1;
        d_addr_i = 32'h600; d_read_i = 1'b1;
        glog = "";
        ngr = 0;
        for (int c = 0; c < 60 && ngr < 10; c++) begin
            tick;
            if (mem_resp_i) begin
                mem_resp_i = 1'b0;
            end else if (mem_read_o || mem_write_o) begin
                glog = {glog, (mem_addr_o == 32'h500) ? "I" : "D"};
                ngr++;
                mem_resp_i = 1'b1;
                mem_rdata_i = mem_addr_o ^ 32'hA5A50000;
            end
        end
`ifdef RVGA_ARB_ROUND_ROBIN_EN
        gexp = "DIDIDIDIDI";
`else
        gexp = "DDDDIDDDDI";
`endif
        n_tests++;
        if (glog != gexp) begin
            n_fail++;
            $display("FAIL grant_order: got %s, expected %s", glog, gexp);
        end
        i_read_i = 1'b0; d_read_i = 1'b0;
        tick;
        mem_resp_i = 1'b0;
        tick;

        // Reset while D owns the port, with I pending
        d_addr_i = 32'h700; d_wdata_i = 32'hCAFEF00D; d_write_i = 1'b1;
        i_addr_i = 32'h800; i_read_i = 1'b1;
        tick;
        chk("t5_mem_write", {31'b0, mem_write_o}, 32'h1);
        chk("t5_mem_addr", mem_addr_o, 32'h700);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_write", {31'b0, mem_write_o}, 32'h0);
        chk("t5_async_addr", mem_addr_o, 32'h0);
        d_write_i = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        mem_resp_i = 1'b1; mem_rdata_i = 32'hBEEF0000;
        #1;
        chk("t5_late_i_resp", {31'b0, i_resp_o}, 32'h0);
        chk("t5_late_d_resp", {31'b0, d_resp_o}, 32'h0);
        tick;
        mem_resp_i = 1'b0;
        chk("t5_i_read", {31'b0, mem_read_o}, 32'h1);
        chk("t5_i_addr", mem_addr_o, 32'h800);
        mem_resp_i = 1'b1; mem_rdata_i = 32'h08000800;
        #1;
        chk("t5_i_resp", {31'b0, i_resp_o}, 32'h1);
        tick;
        i_read_i = 1'b0; mem_resp_i = 1'b0;
        tick;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
